// File: rtl/mux16_rr_arbiter_pkg.sv
// Shared types and constants for the 16-way round-robin result-mux arbiter.
package mux16_rr_arbiter_pkg;

    localparam int unsigned NREQ  = 16;
    localparam int unsigned SEL_W = 4;

    typedef logic [SEL_W-1:0] sel_t;

    typedef enum logic [0:0] {
        StIdle,
        StFull
    } state_e;

    // Binary requester index to one-hot grant vector.
    function automatic logic [NREQ-1:0] idx_to_onehot(input sel_t idx);
        logic [NREQ-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/mux16_to_1.sv
// 16:1 word mux over a flattened input bus; requester i sits at bits [i*SIZE +: SIZE].
module mux16_to_1
    import mux16_rr_arbiter_pkg::*;
#(
    parameter int unsigned SIZE = 32
) (
    input  logic [NREQ*SIZE-1:0] d,
    input  sel_t                 control,
    output logic [SIZE-1:0]      z
);

    logic [SIZE-1:0] words [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign words[i] = d[i*SIZE +: SIZE];
    end

    // Select the word addressed by control.
    always_comb begin
        z = words[control];
    end

endmodule

// File: rtl/rr_pick16.sv
// Round-robin winner pick: rotate so ptr is bit 0, find the lowest set bit,
// then add ptr back to get the absolute index.
module rr_pick16
    import mux16_rr_arbiter_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  sel_t            ptr,
    output logic            valid,
    output sel_t            idx
);

    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    sel_t              off;

    // Rotate, priority-encode, unrotate.
    always_comb begin
        dbl = {req, req} >> ptr;
        rot = dbl[NREQ-1:0];
        off = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = sel_t'(i);
            end
        end
        valid = |req;
        idx   = ptr + off;
    end

endmodule

// File: rtl/mux16_rr_arbiter.sv
// Round-robin arbiter sharing one 16:1 result mux; captures the winner's word
// into an output register and hands it downstream over valid/ready.
module mux16_rr_arbiter
    import mux16_rr_arbiter_pkg::sel_t;
    import mux16_rr_arbiter_pkg::state_e;
    import mux16_rr_arbiter_pkg::StIdle;
    import mux16_rr_arbiter_pkg::StFull;
    import mux16_rr_arbiter_pkg::idx_to_onehot;
#(
    parameter int unsigned SIZE = 32,
    parameter int unsigned NREQ = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*SIZE-1:0] req_data,
    output sel_t                 sel,
    output logic [NREQ-1:0]      gnt,
    output logic [SIZE-1:0]      out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy
);

    state_e          state_q, state_d;
    sel_t            ptr_q;
    sel_t            sel_q;
    logic [NREQ-1:0] gnt_q;
    logic [SIZE-1:0] out_data_q;

    logic            pick_valid;
    sel_t            pick_idx;
    logic [SIZE-1:0] mux_z;
    logic            load;

    rr_pick16 u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    mux16_to_1 #(
        .SIZE (SIZE)
    ) u_mux (
        .d       (req_data),
        .control (sel),
        .z       (mux_z)
    );

    // Capture whenever someone requests and the output slot is free or draining.
    always_comb begin
        load = pick_valid & (~out_valid | out_ready);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (load) state_d = StFull;
            StFull: begin
                if (load) begin
                    state_d = StFull;
                end else if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs; sel only follows the winner on load so it stays put under backpressure.
    always_comb begin
        out_valid = (state_q == StFull);
        gnt       = gnt_q;
        out_data  = out_data_q;
        sel       = load ? pick_idx : sel_q;
        busy      = out_valid | (|req);
    end

    // Datapath: capture the selected word, pulse the grant, advance the pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q <= '0;
            gnt_q      <= '0;
            ptr_q      <= '0;
            sel_q      <= '0;
        end else begin
            sel_q <= sel;
            if (load) begin
                out_data_q <= mux_z;
                gnt_q      <= idx_to_onehot(pick_idx);
                ptr_q      <= pick_idx + sel_t'(1);
            end else begin
                gnt_q      <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Directed bench for mux16_rr_arbiter: inputs driven on the falling edge,
// outputs sampled on the falling edge after each capture edge.
module tb_mux16_rr_arbiter;

    localparam int unsigned SIZE = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [15:0]       req = '0;
    logic [16*SIZE-1:0] req_data;
    logic [3:0]        sel;
    logic [15:0]       gnt;
    logic [SIZE-1:0]   out_data;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic              busy;

    int vectors = 0;
    int miscompares = 0;

    mux16_rr_arbiter #(
        .SIZE (SIZE),
        .NREQ (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_data  (req_data),
        .sel       (sel),
        .gnt       (gnt),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input int i);
        logic [31:0] w;
        w = 32'h1111_1111 * i;
        return w;
    endfunction

    function automatic logic [15:0] oh(input int i);
        logic [15:0] v;
        v = 16'h0001 << i;
        return v;
    endfunction

    task automatic do_reset(input logic [15:0] r, input logic rdy);
        @(negedge clk);
        rst_n = 1'b0;
        req = r;
        out_ready = rdy;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req = 16'hFFFF;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if (sel !== 4'd0 || gnt !== 16'h0 || out_valid !== 1'b0 || out_data !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_state: sel=%h gnt=%h valid=%b data=%h want 0/0/0/0",
                     sel, gnt, out_valid, out_data);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 17; k++) begin
            @(negedge clk);
            vectors++;
            if (gnt !== oh(k % 16) || out_data !== word(k % 16) || out_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL all_req_seq[%0d]: gnt=%h data=%h valid=%b want %h/%h/1",
                         k, gnt, out_data, out_valid, oh(k % 16), word(k % 16));
            end
        end
    endtask

    task automatic test_sparse();
        logic [15:0] exp_g [4];
        exp_g[0] = 16'h0004; exp_g[1] = 16'h8000; exp_g[2] = 16'h0004; exp_g[3] = 16'h8000;
        do_reset(16'h8004, 1'b1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            vectors++;
            if (gnt !== exp_g[k]) begin
                miscompares++;
                $display("FAIL sparse_rr[%0d]: gnt=%h want %h", k, gnt, exp_g[k]);
            end
        end
        req = 16'h0004;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            vectors++;
            if (gnt !== 16'h0004 || out_data !== word(2)) begin
                miscompares++;
                $display("FAIL sparse_drop[%0d]: gnt=%h data=%h want 0004/%h",
                         k, gnt, out_data, word(2));
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset(16'h0010, 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            vectors++;
            if (gnt !== ((k == 0) ? 16'h0010 : 16'h0000) || out_valid !== 1'b1 ||
                out_data !== word(4) || sel !== 4'd4) begin
                miscompares++;
                $display("FAIL backpressure[%0d]: gnt=%h valid=%b data=%h sel=%0d", k, gnt,
                         out_valid, out_data, sel);
            end
        end
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            vectors++;
            if (gnt !== 16'h0010 || out_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL bp_resume[%0d]: gnt=%h valid=%b want 0010/1", k, gnt, out_valid);
            end
        end
    endtask

    task automatic test_wrap();
        do_reset(16'h4000, 1'b1);
        @(negedge clk);
        vectors++;
        if (gnt !== 16'h4000) begin
            miscompares++;
            $display("FAIL wrap_first: gnt=%h want 4000", gnt);
        end
        req = 16'h8001;
        #1;
        vectors++;
        if (sel !== 4'd15) begin
            miscompares++;
            $display("FAIL wrap_sel: sel=%0d want 15", sel);
        end
        @(negedge clk);
        vectors++;
        if (gnt !== 16'h8000 || out_data !== word(15)) begin
            miscompares++;
            $display("FAIL wrap_15: gnt=%h data=%h want 8000/%h", gnt, out_data, word(15));
        end
        @(negedge clk);
        vectors++;
        if (gnt !== 16'h0001 || out_data !== word(0)) begin
            miscompares++;
            $display("FAIL wrap_0: gnt=%h data=%h want 0001/%h", gnt, out_data, word(0));
        end
    endtask

    task automatic test_async_reset();
        do_reset(16'h0020, 1'b0);
        @(negedge clk);
        vectors++;
        if (gnt !== 16'h0020 || out_valid !== 1'b1 || out_data !== word(5)) begin
            miscompares++;
            $display("FAIL async_pre: gnt=%h valid=%b data=%h", gnt, out_valid, out_data);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || gnt !== 16'h0) begin
            miscompares++;
            $display("FAIL async_drop: valid=%b data=%h gnt=%h want 0/0/0",
                     out_valid, out_data, gnt);
        end
        @(negedge clk);
        req = 16'h0041;
        out_ready = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (gnt !== 16'h0001) begin
            miscompares++;
            $display("FAIL async_ptr0: gnt=%h want 0001", gnt);
        end
    endtask

    task automatic test_idle_drain();
        do_reset(16'h0080, 1'b1);
        @(negedge clk);
        vectors++;
        if (gnt !== 16'h0080 || out_valid !== 1'b1 || busy !== 1'b1 || out_data !== word(7)) begin
            miscompares++;
            $display("FAIL drain_load: gnt=%h valid=%b busy=%b data=%h", gnt, out_valid, busy,
                     out_data);
        end
        req = 16'h0000;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            vectors++;
            if (gnt !== 16'h0 || out_valid !== 1'b0 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL drain_idle[%0d]: gnt=%h valid=%b busy=%b want 0/0/0",
                         k, gnt, out_valid, busy);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            req_data[i*SIZE +: SIZE] = word(i);
        end
        test_reset();
        test_sparse();
        test_backpressure();
        test_wrap();
        test_async_reset();
        test_idle_drain();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
